// File: rtl/auth_req_arbiter_if.sv
// Requester/responder bundle for auth_req_arbiter.
// Latency: none (wires only).
// Backpressure: none here; arbiter holds requests until granted and owns resp_req/resp_ack.
//
// Ports (grouped signals):
//   req_valid   - per-requester pending request (level)
//   req_msg     - per-requester message, slice i = [(i+1)*MSG_LEN-1 : i*MSG_LEN]
//   req_grant   - one-hot grant pulse, message of that requester captured
//   resp_req    - level request to the responder
//   auth_msg    - captured message presented to the responder
//   resp_done   - responder completion
//   resp_ack    - one-cycle acknowledge to the responder
//   done_pulse  - one-hot pulse, owner's transaction completed
//   timeout_err - one-hot pulse, owner's transaction timed out
// Modports: master = arbiter side, slave = requester/responder side.

`ifndef MSG_LEN
`define MSG_LEN 16
`endif

interface auth_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*`MSG_LEN-1:0] req_msg;
    logic [NUM_REQ-1:0]          req_grant;
    logic                        resp_req;
    logic [`MSG_LEN-1:0]         auth_msg;
    logic                        resp_done;
    logic                        resp_ack;
    logic [NUM_REQ-1:0]          done_pulse;
    logic [NUM_REQ-1:0]          timeout_err;

    modport master (
        input  req_valid, req_msg, resp_done,
        output req_grant, resp_req, auth_msg, resp_ack, done_pulse, timeout_err
    );

    modport slave (
        output req_valid, req_msg, resp_done,
        input  req_grant, resp_req, auth_msg, resp_ack, done_pulse, timeout_err
    );
endinterface

// File: rtl/auth_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one responder, one transaction at a time.
// Latency: grant in the IDLE cycle a request is seen, resp_req one cycle later; min 4 cycles between grants.
// Backpressure: requests wait (held level) while a transaction is in flight; responder paced by resp_done.
//
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-low reset
//   bus   - auth_req_arbiter_if.master (request, grant, responder handshake, status pulses)
// Parameters: NUM_REQ (2..8), TIMEOUT_CYCLES (2..65535).
// Build option: define AUTH_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.

`ifndef MSG_LEN
`define MSG_LEN 16
`endif

module auth_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    auth_req_arbiter_if.master   bus
);

    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        ISSUE     = 5'b00010,
        WAIT_RESP = 5'b00100,
        ACK       = 5'b01000,
        DRAIN     = 5'b10000
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [`MSG_LEN-1:0]  auth_msg_q, auth_msg_d;
    logic                 resp_ack_q, resp_ack_d;
    logic [NUM_REQ-1:0]   done_pulse_q, done_pulse_d;
    logic [NUM_REQ-1:0]   timeout_err_q, timeout_err_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;
    logic [NUM_REQ-1:0]   grant_vec;
    logic [NUM_REQ-1:0]   owner_onehot;

`ifdef AUTH_ARB_ROUND_ROBIN_EN
    // Index where the next search starts: one past the last winner.
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

    // Winner select. Walk the candidates from the farthest to the nearest so
    // the last hit (nearest to the search start) is the one that sticks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
`ifdef AUTH_ARB_ROUND_ROBIN_EN
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
`else
            cand = off;
`endif
            cand_idx = IDX_W'(cand);
            if (bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign owner_onehot = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        auth_msg_d    = auth_msg_q;
        resp_ack_d    = 1'b0;
        done_pulse_d  = '0;
        timeout_err_d = '0;
        grant_vec     = '0;
`ifdef AUTH_ARB_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_vec  = NUM_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    auth_msg_d = bus.req_msg[int'(win_idx)*`MSG_LEN +: `MSG_LEN];
                    state_d    = ISSUE;
`ifdef AUTH_ARB_ROUND_ROBIN_EN
                    ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                // Completion is checked first so it wins a same-cycle tie with the timeout.
                if (bus.resp_done) begin
                    resp_ack_d   = 1'b1;
                    done_pulse_d = owner_onehot;
                    state_d      = ACK;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = owner_onehot;
                    cnt_d         = '0;
                    state_d       = DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ACK: begin
                if (!bus.resp_done) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Two dead cycles so the responder can settle; resp_done is ignored.
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            owner_q       <= '0;
            auth_msg_q    <= '0;
            resp_ack_q    <= 1'b0;
            done_pulse_q  <= '0;
            timeout_err_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            auth_msg_q    <= auth_msg_d;
            resp_ack_q    <= resp_ack_d;
            done_pulse_q  <= done_pulse_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef AUTH_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // The grant is decoded from IDLE plus live req_valid, so it is masked by
    // reset directly to stay low while reset is held.
    assign bus.req_grant   = grant_vec & {NUM_REQ{reset}};
    assign bus.resp_req    = (state_q == ISSUE) || (state_q == WAIT_RESP);
    assign bus.auth_msg    = auth_msg_q;
    assign bus.resp_ack    = resp_ack_q;
    assign bus.done_pulse  = done_pulse_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_auth_req_arbiter.sv
// Randomized self-checking bench for auth_req_arbiter.
// Latency: n/a.
// Backpressure: n/a.

`ifndef MSG_LEN
`define MSG_LEN 16
`endif

module tb_auth_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam int ML = `MSG_LEN;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   rr_ptr   = 0;

    always #5 clk = ~clk;

    auth_req_arbiter_if #(.NUM_REQ(N)) bus ();

    auth_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arbitration: plain search over the request bits.
    function automatic int model_winner(input logic [N-1:0] v);
`ifdef AUTH_ARB_ROUND_ROBIN_EN
        for (int off = 0; off < N; off++) begin
            if (v[(rr_ptr + off) % N]) return (rr_ptr + off) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N*ML-1:0] rand_msgs();
        logic [N*ML-1:0] m;
        for (int i = 0; i < N; i++) m[i*ML +: ML] = ML'($urandom);
        return m;
    endfunction

    // One complete transaction seen from the requester/responder side.
    // done_at: WAIT_RESP cycle index where resp_done rises; <0 or >=TO means never in time.
    // hold: extra ACK cycles the responder keeps resp_done high.
    task automatic run_txn(input logic [N-1:0] v, input logic [N*ML-1:0] m, input int done_at,
                           input int hold, input bit scramble, output int w);
        logic [ML-1:0] x;
        bit            done_path;
        int            jlast;
        @(posedge clk); #1;
        bus.req_valid = v;
        bus.req_msg   = m;
        bus.resp_done = 1'b0;
        @(negedge clk);
        w = model_winner(v);
        chk_eq("grant", 32'(bus.req_grant), 32'(1) << w);
        chk_eq("resp_req_idle", 32'(bus.resp_req), 0);
`ifdef AUTH_ARB_ROUND_ROBIN_EN
        rr_ptr = (w + 1) % N;
`endif
        x = m[w*ML +: ML];

        @(posedge clk); #1;
        if (scramble) bus.req_msg = rand_msgs();
        @(negedge clk);
        chk_eq("grant_issue", 32'(bus.req_grant), 0);
        chk_eq("resp_req_issue", 32'(bus.resp_req), 1);
        chk_eq("auth_msg_issue", 32'(bus.auth_msg), 32'(x));

        done_path = (done_at >= 0) && (done_at <= TO - 1);
        jlast     = done_path ? done_at : TO - 1;
        for (int j = 0; j <= jlast; j++) begin
            @(posedge clk); #1;
            bus.resp_done = done_path && (j == done_at);
            if (scramble) begin
                bus.req_msg   = rand_msgs();
                bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
            end
            @(negedge clk);
            chk_eq("resp_req_wait", 32'(bus.resp_req), 1);
            chk_eq("auth_msg_wait", 32'(bus.auth_msg), 32'(x));
            chk_eq("ack_wait", 32'(bus.resp_ack), 0);
            chk_eq("done_wait", 32'(bus.done_pulse), 0);
            chk_eq("tmo_wait", 32'(bus.timeout_err), 0);
            chk_eq("grant_wait", 32'(bus.req_grant), 0);
        end

        if (done_path) begin
            for (int k = 0; k <= hold; k++) begin
                @(posedge clk); #1;
                bus.resp_done = (k < hold);
                bus.req_valid = v;
                @(negedge clk);
                chk_eq("resp_req_ack", 32'(bus.resp_req), 0);
                chk_eq("resp_ack", 32'(bus.resp_ack), (k == 0) ? 1 : 0);
                chk_eq("done_pulse", 32'(bus.done_pulse), (k == 0) ? (32'(1) << w) : 0);
                chk_eq("tmo_ack", 32'(bus.timeout_err), 0);
                chk_eq("grant_ack", 32'(bus.req_grant), 0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                bus.resp_done = 1'($urandom);
                bus.req_valid = v;
                @(negedge clk);
                chk_eq("resp_req_drain", 32'(bus.resp_req), 0);
                chk_eq("timeout_err", 32'(bus.timeout_err), (k == 0) ? (32'(1) << w) : 0);
                chk_eq("ack_drain", 32'(bus.resp_ack), 0);
                chk_eq("done_drain", 32'(bus.done_pulse), 0);
                chk_eq("grant_drain", 32'(bus.req_grant), 0);
            end
        end
    endtask

    // Status vectors must never have more than one bit set.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk_eq("onehot", 32'(($countones(bus.req_grant) <= 1) &&
                                 ($countones(bus.done_pulse) <= 1) &&
                                 ($countones(bus.timeout_err) <= 1)), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int order [5];
        logic [N*ML-1:0] m;
        int r;
`ifdef AUTH_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_msg   = '0;
        bus.resp_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_grant", 32'(bus.req_grant), 0);
        chk_eq("rst_resp_req", 32'(bus.resp_req), 0);
        chk_eq("rst_ack", 32'(bus.resp_ack), 0);
        chk_eq("rst_msg", 32'(bus.auth_msg), 0);
        chk_eq("rst_done", 32'(bus.done_pulse), 0);
        chk_eq("rst_tmo", 32'(bus.timeout_err), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single request, completion at WAIT_RESP cycle 5.
        m = rand_msgs();
        run_txn(4'b0010, m, 5, 1, 1'b0, w);
        chk_eq("single_winner", 32'(w), 1);

        // Message change after grant is ignored.
        m = rand_msgs();
        run_txn(4'b0001, m, 3, 0, 1'b1, w);

        // Contention with all requesters held high.
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, rand_msgs(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, w);
            chk_eq("order", 32'(w), 32'(order[t]));
        end

        // Timeout, then tie (completion wins), then one cycle too late.
        run_txn(4'b0100, rand_msgs(), -1, 0, 1'b0, w);
        run_txn(4'b1000, rand_msgs(), TO - 1, 1, 1'b0, w);
        run_txn(4'b0110, rand_msgs(), TO, 0, 1'b0, w);

        // Asynchronous reset in the middle of WAIT_RESP.
        @(posedge clk); #1;
        bus.req_valid = 4'b0100;
        bus.req_msg   = rand_msgs();
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        reset         = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        chk_eq("arst_resp_req", 32'(bus.resp_req), 0);
        chk_eq("arst_grant", 32'(bus.req_grant), 0);
        chk_eq("arst_msg", 32'(bus.auth_msg), 0);
        @(posedge clk); #1;
        chk_eq("arst_ack", 32'(bus.resp_ack), 0);
        chk_eq("arst_done", 32'(bus.done_pulse), 0);
        chk_eq("arst_tmo", 32'(bus.timeout_err), 0);
        chk_eq("arst_grant_held", 32'(bus.req_grant), 0);
        bus.req_valid = '0;
        #2;
        reset  = 1'b1;
        rr_ptr = 0;
        @(negedge clk);
        chk_eq("post_rst_grant", 32'(bus.req_grant), 0);
        chk_eq("post_rst_resp_req", 32'(bus.resp_req), 0);
        run_txn(4'b0001, rand_msgs(), 2, 0, 1'b0, w);
        chk_eq("post_rst_winner", 32'(w), 0);
        run_txn(4'b0101, rand_msgs(), 1, 0, 1'b0, w);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                bus.req_valid = '0;
                bus.resp_done = 1'b0;
                @(negedge clk);
                chk_eq("idle_grant", 32'(bus.req_grant), 0);
                chk_eq("idle_resp_req", 32'(bus.resp_req), 0);
            end
            r = int'($urandom_range(0, 9));
            run_txn(N'($urandom_range(1, (1 << N) - 1)), rand_msgs(), (r == 9) ? -1 : r,
                    int'($urandom_range(0, 3)), 1'b1, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
